// File: rtl/az_wb_if.sv
// az_wb_if: bundles the execute-side handshake, the data-memory load
// response and the register-file write port of the az_cpu writeback stage.
interface az_wb_if;
  // Upstream instruction handshake
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        ex_is_load;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_addr_lo;
  // Data-memory load response
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        dmem_rerr;
  // Register-file write port and status
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        load_pending;
  logic [4:0]  pending_rd;
  logic        wb_fault;
  logic [31:0] instret;

  // Pipeline / memory side: drives instructions and load responses
  modport master (
    output ex_valid, ex_rd, ex_result, ex_is_load, ex_funct3, ex_addr_lo,
    output dmem_rvalid, dmem_rdata, dmem_rerr,
    input  ex_ready, gpr_wen, gpr_waddr, gpr_wdata,
    input  load_pending, pending_rd, wb_fault, instret
  );

  // Writeback stage side
  modport slave (
    input  ex_valid, ex_rd, ex_result, ex_is_load, ex_funct3, ex_addr_lo,
    input  dmem_rvalid, dmem_rdata, dmem_rerr,
    output ex_ready, gpr_wen, gpr_waddr, gpr_wdata,
    output load_pending, pending_rd, wb_fault, instret
  );
endinterface

// File: rtl/az_wb.sv
// az_wb: writeback stage of the az_cpu pipeline. ALU results are registered
// straight into the register-file write port; loads park in WAIT_LOAD until
// the data-memory response arrives, then get byte/half extracted and
// extended. Faulting loads pulse wb_fault instead of writing.
module az_wb (
  input  logic    cpu_clk,
  input  logic    cpu_rstn,
  az_wb_if.slave  wb
);

  localparam logic [0:0] ST_IDLE      = 1'b0;
  localparam logic [0:0] ST_WAIT_LOAD = 1'b1;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // A load faults on a bus error, an unknown load type, or a misaligned
  // halfword/word access.
  function automatic logic load_faults(input logic [2:0] f3,
                                       input logic [1:0] lo,
                                       input logic       rerr);
    logic bad;
    case (f3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = lo[0];
      F3_LW:         bad = (lo != 2'd0);
      default:       bad = 1'b1;
    endcase
    return rerr | bad;
  endfunction

  // Select the addressed byte/half from the little-endian response word
  // and extend it according to the load type.
  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  lo,
                                               input logic [31:0] rdata);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res;
    byte_v = rdata[{lo, 3'b000} +: 8];
    half_v = rdata[{lo[1], 4'b0000} +: 16];
    case (f3)
      F3_LB:   res = {{24{byte_v[7]}}, byte_v};
      F3_LH:   res = {{16{half_v[15]}}, half_v};
      F3_LW:   res = rdata;
      F3_LBU:  res = {24'd0, byte_v};
      F3_LHU:  res = {16'd0, half_v};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  logic [0:0]  state_r;
  logic [4:0]  pend_rd_r;
  logic [2:0]  pend_f3_r;
  logic [1:0]  pend_lo_r;
  logic        gpr_wen_r;
  logic [4:0]  gpr_waddr_r;
  logic [31:0] gpr_wdata_r;
  logic        wb_fault_r;
  logic [31:0] instret_r;

  logic        accept_s;
  logic        alu_acc_s;
  logic        ld_acc_s;
  logic        resp_s;
  logic        fault_s;
  logic        retire_s;
  logic [31:0] ld_data_s;

  // Handshake decode and load-response evaluation
  always_comb begin
    accept_s  = wb.ex_valid & (state_r == ST_IDLE);
    alu_acc_s = accept_s & ~wb.ex_is_load;
    ld_acc_s  = accept_s & wb.ex_is_load;
    resp_s    = (state_r == ST_WAIT_LOAD) & wb.dmem_rvalid;
    fault_s   = load_faults(pend_f3_r, pend_lo_r, wb.dmem_rerr);
    ld_data_s = load_extract(pend_f3_r, pend_lo_r, wb.dmem_rdata);
    if (resp_s) begin
      retire_s = ~fault_s;
    end else begin
      retire_s = alu_acc_s;
    end
  end

  // FSM and captured load descriptor; pending_rd reads 0 when nothing waits
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_r   <= ST_IDLE;
      pend_rd_r <= 5'd0;
      pend_f3_r <= 3'd0;
      pend_lo_r <= 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ld_acc_s) begin
            state_r   <= ST_WAIT_LOAD;
            pend_rd_r <= wb.ex_rd;
            pend_f3_r <= wb.ex_funct3;
            pend_lo_r <= wb.ex_addr_lo;
          end
        end
        ST_WAIT_LOAD: begin
          if (resp_s) begin
            state_r   <= ST_IDLE;
            pend_rd_r <= 5'd0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          pend_rd_r <= 5'd0;
        end
      endcase
    end
  end

  // Register-file write port and fault pulse; address/data hold when idle
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      gpr_wen_r   <= 1'b0;
      gpr_waddr_r <= 5'd0;
      gpr_wdata_r <= 32'd0;
      wb_fault_r  <= 1'b0;
    end else begin
      gpr_wen_r  <= 1'b0;
      wb_fault_r <= 1'b0;
      if (alu_acc_s) begin
        if (wb.ex_rd != 5'd0) begin
          gpr_wen_r   <= 1'b1;
          gpr_waddr_r <= wb.ex_rd;
          gpr_wdata_r <= wb.ex_result;
        end
      end else if (resp_s) begin
        if (fault_s) begin
          wb_fault_r <= 1'b1;
        end else if (pend_rd_r != 5'd0) begin
          gpr_wen_r   <= 1'b1;
          gpr_waddr_r <= pend_rd_r;
          gpr_wdata_r <= ld_data_s;
        end
      end
    end
  end

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      instret_r <= 32'd0;
    end else if (retire_s) begin
      instret_r <= instret_r + 32'd1;
    end
  end

  assign wb.ex_ready     = (state_r == ST_IDLE);
  assign wb.load_pending = (state_r == ST_WAIT_LOAD);
  assign wb.pending_rd   = pend_rd_r;
  assign wb.gpr_wen      = gpr_wen_r;
  assign wb.gpr_waddr    = gpr_waddr_r;
  assign wb.gpr_wdata    = gpr_wdata_r;
  assign wb.wb_fault     = wb_fault_r;
  assign wb.instret      = instret_r;

endmodule

// File: tb/tb_az_wb.sv
// tb_az_wb: scoreboard bench for az_wb. The driver pushes the expected
// register write (or fault) with the cycle it must appear; a negedge monitor
// pops and compares whenever the DUT writes or faults.
module tb_az_wb;

  logic cpu_clk = 1'b0;
  logic cpu_rstn = 1'b0;

  az_wb_if bus ();

  az_wb dut (
    .cpu_clk (cpu_clk),
    .cpu_rstn(cpu_rstn),
    .wb      (bus)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    bit          is_fault;
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t         exp_q[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_instret = 32'd0;
  logic [4:0]  last_addr = 5'd0;
  logic [31:0] last_data = 32'd0;

  always @(posedge cpu_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: fault rules and extraction by shift/mask arithmetic
  function automatic bit ref_fault(input int f3, input int lo, input bit rerr);
    if (rerr) return 1'b1;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if ((f3 == 1 || f3 == 5) && (lo % 2) == 1) return 1'b1;
    if (f3 == 2 && lo != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_value(input int f3, input int lo, input logic [31:0] w);
    logic [31:0] v;
    v = 32'd0;
    case (f3)
      0, 4: begin
        v = (w >> (8 * lo)) & 32'h0000_00FF;
        if (f3 == 0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      1, 5: begin
        v = (w >> (16 * (lo / 2))) & 32'h0000_FFFF;
        if (f3 == 1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      2: v = w;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  // Monitor: compare every write/fault against the scoreboard head
  always @(negedge cpu_clk) begin
    if (!cpu_rstn) begin
      last_addr = 5'd0;
      last_data = 32'd0;
    end else if (bus.gpr_wen || bus.wb_fault) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got wen=%0b fault=%0b addr=%0d data=0x%08h want none (cyc=%0d)",
                 bus.gpr_wen, bus.wb_fault, bus.gpr_waddr, bus.gpr_wdata, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (bus.wb_fault !== e.is_fault || bus.gpr_wen !== !e.is_fault || e.cyc != cyc ||
            (!e.is_fault && (bus.gpr_waddr !== e.addr || bus.gpr_wdata !== e.data))) begin
          errors++;
          $display("FAIL wb_event: got wen=%0b fault=%0b addr=%0d data=0x%08h cyc=%0d want fault=%0b addr=%0d data=0x%08h cyc=%0d",
                   bus.gpr_wen, bus.wb_fault, bus.gpr_waddr, bus.gpr_wdata, cyc,
                   e.is_fault, e.addr, e.data, e.cyc);
        end
        if (bus.gpr_wen) begin
          last_addr = bus.gpr_waddr;
          last_data = bus.gpr_wdata;
        end
      end
    end else begin
      checks++;
      if (bus.gpr_waddr !== last_addr || bus.gpr_wdata !== last_data) begin
        errors++;
        $display("FAIL hold: got addr=%0d data=0x%08h want addr=%0d data=0x%08h",
                 bus.gpr_waddr, bus.gpr_wdata, last_addr, last_data);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        ev_t e;
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_event: got nothing want fault=%0b addr=%0d data=0x%08h at cyc=%0d",
                 e.is_fault, e.addr, e.data, e.cyc);
      end
    end
  end

  task automatic idle_inputs();
    bus.ex_valid    = 1'b0;
    bus.ex_rd       = 5'd0;
    bus.ex_result   = 32'd0;
    bus.ex_is_load  = 1'b0;
    bus.ex_funct3   = 3'd0;
    bus.ex_addr_lo  = 2'd0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = 32'd0;
    bus.dmem_rerr   = 1'b0;
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] res);
    ev_t e;
    chk("ready_before_alu", {31'd0, bus.ex_ready}, 32'd1);
    bus.ex_valid   = 1'b1;
    bus.ex_is_load = 1'b0;
    bus.ex_rd      = rd;
    bus.ex_result  = res;
    if (rd != 5'd0) begin
      e.is_fault = 1'b0; e.addr = rd; e.data = res; e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
    m_instret++;
    tick();
    bus.ex_valid = 1'b0;
    chk("instret_alu", bus.instret, m_instret);
  endtask

  task automatic load(input logic [4:0] rd, input int f3, input int lo,
                      input logic [31:0] rdata, input bit rerr, input int wait_n, input bit junk);
    ev_t e;
    chk("ready_before_load", {31'd0, bus.ex_ready}, 32'd1);
    bus.ex_valid   = 1'b1;
    bus.ex_is_load = 1'b1;
    bus.ex_rd      = rd;
    bus.ex_funct3  = f3[2:0];
    bus.ex_addr_lo = lo[1:0];
    bus.ex_result  = $urandom;
    tick();
    bus.ex_valid = 1'b0;
    chk("load_pending", {31'd0, bus.load_pending}, 32'd1);
    chk("pending_rd", {27'd0, bus.pending_rd}, {27'd0, rd});
    chk("ready_wait", {31'd0, bus.ex_ready}, 32'd0);
    for (int i = 0; i < wait_n; i++) begin
      if (junk) begin
        bus.ex_valid   = $urandom_range(0, 1) == 1;
        bus.ex_is_load = $urandom_range(0, 1) == 1;
        bus.ex_rd      = $urandom_range(1, 31);
        bus.ex_result  = $urandom;
      end
      tick();
      chk("ready_wait", {31'd0, bus.ex_ready}, 32'd0);
      chk("pending_rd_wait", {27'd0, bus.pending_rd}, {27'd0, rd});
    end
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = rdata;
    bus.dmem_rerr   = rerr;
    e.cyc = cyc + 1;
    if (ref_fault(f3, lo, rerr)) begin
      e.is_fault = 1'b1; e.addr = 5'd0; e.data = 32'd0;
      exp_q.push_back(e);
    end else begin
      m_instret++;
      if (rd != 5'd0) begin
        e.is_fault = 1'b0; e.addr = rd; e.data = ref_value(f3, lo, rdata);
        exp_q.push_back(e);
      end
    end
    tick();
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rerr   = 1'b0;
    bus.ex_valid    = 1'b0;
    chk("pending_cleared", {31'd0, bus.load_pending}, 32'd0);
    chk("pending_rd_cleared", {27'd0, bus.pending_rd}, 32'd0);
    chk("ready_after_resp", {31'd0, bus.ex_ready}, 32'd1);
    chk("instret_load", bus.instret, m_instret);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    cpu_rstn = 1'b0;
    repeat (2) tick();
    chk("rst_gpr_wen", {31'd0, bus.gpr_wen}, 32'd0);
    chk("rst_gpr_waddr", {27'd0, bus.gpr_waddr}, 32'd0);
    chk("rst_gpr_wdata", bus.gpr_wdata, 32'd0);
    chk("rst_wb_fault", {31'd0, bus.wb_fault}, 32'd0);
    chk("rst_instret", bus.instret, 32'd0);
    chk("rst_load_pending", {31'd0, bus.load_pending}, 32'd0);
    chk("rst_pending_rd", {27'd0, bus.pending_rd}, 32'd0);
    chk("rst_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
    cpu_rstn = 1'b1;
    tick();

    // Directed cases
    alu(5'd5, 32'h1234_5678);
    alu(5'd1, 32'hAAAA_0001);
    alu(5'd2, 32'hBBBB_0002);
    alu(5'd0, 32'hCCCC_0000);
    tick();
    load(5'd7, 0, 3, 32'h80FF_0011, 1'b0, 4, 1'b0);
    load(5'd8, 5, 2, 32'h9ABC_1234, 1'b0, 1, 1'b0);
    load(5'd9, 1, 2, 32'h9ABC_1234, 1'b0, 0, 1'b0);
    load(5'd10, 2, 1, 32'hDEAD_BEEF, 1'b0, 2, 1'b0);
    load(5'd11, 2, 0, 32'hDEAD_BEEF, 1'b1, 1, 1'b0);
    load(5'd12, 2, 0, 32'hCAFE_F00D, 1'b0, 3, 1'b1);
    load(5'd0, 4, 1, 32'h0000_5500, 1'b0, 0, 1'b0);

    // Reset in the middle of a load
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd13;
    bus.ex_funct3 = 3'd2; bus.ex_addr_lo = 2'd0;
    tick();
    bus.ex_valid = 1'b0;
    tick();
    #2;
    cpu_rstn = 1'b0;
    m_instret = 32'd0;
    #1;
    chk("midrst_load_pending", {31'd0, bus.load_pending}, 32'd0);
    chk("midrst_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
    chk("midrst_pending_rd", {27'd0, bus.pending_rd}, 32'd0);
    chk("midrst_instret", bus.instret, 32'd0);
    chk("midrst_gpr_wdata", bus.gpr_wdata, 32'd0);
    tick();
    cpu_rstn = 1'b1;
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h1111_2222;
    tick();
    bus.dmem_rvalid = 1'b0;
    repeat (2) tick();
    chk("postrst_instret", bus.instret, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [4:0] rd;
      r  = $urandom_range(0, 9);
      rd = $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) rd = 5'd0;
      if (r <= 3) begin
        alu(rd, $urandom);
      end else if (r <= 7) begin
        load(rd, $urandom_range(0, 7), $urandom_range(0, 3), $urandom,
             $urandom_range(0, 7) == 0, $urandom_range(0, 4), $urandom_range(0, 1) == 1);
      end else if (r == 8) begin
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = $urandom;
        bus.dmem_rerr   = $urandom_range(0, 1) == 1;
        tick();
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rerr   = 1'b0;
        chk("instret_stray", bus.instret, m_instret);
      end else begin
        tick();
      end
    end

    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
